// File: rtl/hilo_muldiv_pkg.sv
// Shared MIPS datapath definitions: ALU control codes, HI/LO unit op codes,
// the multiply/divide FSM states and operand helpers.
package hilo_muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MADD  = 3'd2;
  localparam logic [2:0] OP_MADDU = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } md_state_e;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_DIV);
  endfunction

  // Magnitude of a two's complement value; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_seq_divider.sv
// Unsigned 32-cycle restoring divider core. done is high during the cycle
// whose closing edge performs the last iteration.
module seq_divider
  import hilo_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic            active_q;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic [XLEN:0]   shifted, diff;
  logic            fits;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = shifted >= {1'b0, dvs_q};
    diff    = shifted - {1'b0, dvs_q};
  end

  assign done      = active_q && (cnt_q == 6'(ITERS - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      quo_q    <= dividend;
      rem_q    <= '0;
      dvs_q    <= divisor;
    end else if (active_q) begin
      // Quotient bits shift in from the right as dividend bits shift out.
      rem_q <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], fits};
      cnt_q <= cnt_q + 6'd1;
      if (done) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair:
// MULT/MULTU/MADD/MADDU/DIV/DIVU in 32 iterations, MTHI/MTLO in one cycle.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_e         state_q;
  logic [5:0]        cnt_q;
  logic [2:0]        op_q;
  logic              sa_q, sb_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic              busy_q, done_q, dbz_q;

  logic              sgn, is_div, accept, div_start;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] acc_step, prod, madd;
  logic              div_last;
  logic [XLEN-1:0]   quo, rem, quo_fix, rem_fix;

  always_comb begin
    sgn       = is_signed_op(op);
    a_mag     = mag(a, sgn);
    b_mag     = mag(b, sgn);
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    accept    = (state_q == S_IDLE) && start;
    div_start = accept && is_div && (b != '0);
  end

  seq_divider u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_last),
    .quotient  (quo),
    .remainder (rem)
  );

  // Shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the 65-bit result right, retiring one multiplier bit.
  always_comb begin
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
    acc_step = {sum, acc_q[XLEN-1:1]};
    prod     = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;
    madd     = {hi_q, lo_q} + prod;
    quo_fix  = (sa_q ^ sb_q) ? (~quo + 32'd1) : quo;
    rem_fix  = sa_q ? (~rem + 32'd1) : rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MTHI || op == OP_MTLO) begin
              if (op == OP_MTHI) hi_q <= a;
              else               lo_q <= a;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (is_div && b == '0) begin
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              op_q    <= op;
              sa_q    <= sgn & a[XLEN-1];
              sb_q    <= sgn & b[XLEN-1];
              mcand_q <= a_mag;
              acc_q   <= {{XLEN{1'b0}}, b_mag};
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= is_div ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(ITERS - 1)) state_q <= S_FIX;
        end
        S_DIV: begin
          if (div_last) state_q <= S_FIX;
        end
        S_FIX: begin
          case (op_q)
            OP_MULT, OP_MULTU: {hi_q, lo_q} <= prod;
            OP_MADD, OP_MADDU: {hi_q, lo_q} <= madd;
            default: begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end
          endcase
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: begin
          done_q  <= 1'b0;
          dbz_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: multiply, multiply-accumulate, divide,
// register moves, divide-by-zero, ignored mid-op requests and async reset.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  hilo_muldiv dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op once the unit is idle; returns the cycle number (1 = the
  // cycle after the accepting edge) in which done was seen, or 60 on timeout.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int cyc);
    int guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b hi=%h lo=%h, want all zero",
               busy, done, div_by_zero, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mult();
    int c;
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, c);
    checks++;
    if (c !== 34 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mult_latency: done in cycle %0d busy=%b, want cycle 34 busy=0", c, busy);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL mult_result: hi=%h lo=%h, want ffffffff fffffff1", hi, lo);
    end
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c);
    checks++;
    if (c !== 34 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_result: cyc=%0d hi=%h lo=%h, want 34 fffffffe 00000001", c, hi, lo);
    end
  endtask

  task automatic test_mt_madd();
    int c;
    run_op(3'd6, 32'h0, 32'h0, c);
    checks++;
    if (c !== 1 || busy !== 1'b0 || hi !== 32'h0) begin
      errors++;
      $display("FAIL mthi: cyc=%0d busy=%b hi=%h, want 1 0 00000000", c, busy, hi);
    end
    run_op(3'd7, 32'd10, 32'h0, c);
    checks++;
    if (c !== 1 || busy !== 1'b0 || lo !== 32'd10) begin
      errors++;
      $display("FAIL mtlo: cyc=%0d busy=%b lo=%h, want 1 0 0000000a", c, busy, lo);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo_done_pulse: done=%b in cycle 2, want 0", done);
    end
    run_op(3'd2, 32'd2, 32'd3, c);
    checks++;
    if (c !== 34 || hi !== 32'h0 || lo !== 32'd16) begin
      errors++;
      $display("FAIL madd: cyc=%0d hi=%h lo=%h, want 34 00000000 00000010", c, hi, lo);
    end
    run_op(3'd7, 32'hFFFF_FFFF, 32'h0, c);
    run_op(3'd3, 32'd1, 32'd1, c);
    checks++;
    if (c !== 34 || hi !== 32'd1 || lo !== 32'h0) begin
      errors++;
      $display("FAIL maddu_carry: cyc=%0d hi=%h lo=%h, want 34 00000001 00000000", c, hi, lo);
    end
  endtask

  task automatic test_div();
    int c;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, c);
    checks++;
    if (c !== 34 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_neg: cyc=%0d hi=%h lo=%h, want 34 ffffffff fffffffd", c, hi, lo);
    end
    run_op(3'd5, 32'd7, 32'd2, c);
    checks++;
    if (c !== 34 || lo !== 32'd3 || hi !== 32'd1) begin
      errors++;
      $display("FAIL divu: cyc=%0d hi=%h lo=%h, want 34 00000001 00000003", c, hi, lo);
    end
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, c);
    checks++;
    if (c !== 34 || lo !== 32'h8000_0000 || hi !== 32'h0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL div_overflow: cyc=%0d hi=%h lo=%h dbz=%b, want 34 00000000 80000000 0",
               c, hi, lo, div_by_zero);
    end
  endtask

  task automatic test_div_zero();
    int c;
    run_op(3'd5, 32'd7, 32'd0, c);
    checks++;
    if (c !== 1 || div_by_zero !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL divzero_flag: cyc=%0d dbz=%b busy=%b, want 1 1 0", c, div_by_zero, busy);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL divzero_hilo: hi=%h lo=%h, want 00000000 80000000", hi, lo);
    end
    @(posedge clk); #1;
    checks++;
    if (div_by_zero !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL divzero_clear: dbz=%b done=%b, want 0 0", div_by_zero, done);
    end
  endtask

  task automatic test_ignore_midop();
    int c;
    int guard = 0;
    run_op(3'd6, 32'h1111_1111, 32'h0, c);
    run_op(3'd7, 32'h2222_2222, 32'h0, c);
    @(negedge clk);
    while ((busy || done) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 35; n++) begin
      if (n == 5) begin
        start = 1'b1; op = 3'd7; a = 32'hDEAD_0000; b = 32'hBEEF_0000;
      end
      if (n == 6) begin
        start = 1'b0; a = 32'h0000_0009; b = 32'h0000_0009;
      end
      if (n == 1 || n == 33) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
          errors++;
          $display("FAIL midop_hold_c%0d: busy=%b done=%b hi=%h lo=%h, want 1 0 11111111 22222222",
                   n, busy, done, hi, lo);
        end
      end
      if (n == 34) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || hi !== 32'h0 || lo !== 32'd42) begin
          errors++;
          $display("FAIL midop_result: done=%b busy=%b hi=%h lo=%h, want 1 0 00000000 0000002a",
                   done, busy, hi, lo);
        end
      end
      if (n == 35) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || lo !== 32'd42) begin
          errors++;
          $display("FAIL midop_no_late_accept: done=%b busy=%b lo=%h, want 0 0 0000002a",
                   done, busy, lo);
        end
      end
      if (n < 35) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_midop();
    int guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1 || lo !== 32'd42) begin
      errors++;
      $display("FAIL prereset_busy: busy=%b lo=%h, want 1 0000002a", busy, lo);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b, want all zero", hi, lo, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; op = 3'd7; a = 32'd5; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || lo !== 32'd5 || hi !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_mtlo: done=%b busy=%b hi=%h lo=%h, want 1 0 00000000 00000005",
               done, busy, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mt_madd();
    test_div();
    test_div_zero();
    test_ignore_midop();
    test_reset_midop();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
